analyse_data: RTL and testbench

Receive path of the SWIPT data link: turns the sampled receive-coil current (ADC) into a bit stream and decodes the response frame sent back after each outgoing command. It sits beside the transmit sequencer in the data block. The sequencer enables reception with `readDataIn` once its blind time expires. It consumes `dataInReady`, `dataIn`, `sumChecker` and `checkSumBit`.

---
 rtl/data_link_pkg.sv | 18 +
 rtl/read_data.sv | 34 +++
 rtl/analyse_data.sv | 129 ++++++++++++
 tb/tb_analyse_data.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/data_link_pkg.sv
// Shared definitions for the SWIPT data link: program code, receive framing
// constants, receiver FSM states and the default bit period.
package data_link_pkg;

    localparam logic [1:0] PROG_DATA           = 2'b11;
    localparam logic [5:0] PREAMBLE_RX         = 6'b101010;
    localparam logic [3:0] STOP_RX             = 4'b0101;
    localparam int         FRAME_BITS          = 27;
    localparam int         BIT_CYCLES_DEFAULT  = 200000;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ALIGN = 2'd1,
        SHIFT = 2'd2,
        CHECK = 2'd3
    } rx_state_e;

endpackage

// File: rtl/read_data.sv
// Hysteresis comparator turning the receive-coil current into a bit level.
// Held at 0 whenever reception is disabled.
module read_data #(
    parameter logic [11:0] HYST = 12'd20
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en_i,
    input  logic [11:0] adc_i,
    input  logic [11:0] mean_i,
    output logic        din_o
);

    logic [12:0] hi_thr;
    logic [12:0] lo_thr;
    logic        din_q;

    // 13-bit thresholds so mean+HYST cannot overflow; the low side floors at 0.
    assign hi_thr = {1'b0, mean_i} + {1'b0, HYST};
    assign lo_thr = (mean_i > HYST) ? {1'b0, mean_i - HYST} : 13'd0;

    always_ff @(posedge clk) begin
        if (!nrst || !en_i) begin
            din_q <= 1'b0;
        end else if ({1'b0, adc_i} > hi_thr) begin
            din_q <= 1'b1;
        end else if ({1'b0, adc_i} < lo_thr) begin
            din_q <= 1'b0;
        end
    end

    assign din_o = din_q;

endmodule

// File: rtl/analyse_data.sv
// Receive path of the SWIPT data link: bit timing, frame shift register,
// receiver FSM and payload/checksum/parity checker.
module analyse_data
    import data_link_pkg::*;
#(
    parameter int          BIT_CYCLES = BIT_CYCLES_DEFAULT,
    parameter logic [11:0] HYST       = 12'd20
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive_i,
    input  logic [1:0]  program_i,
    input  logic        readDataIn_i,
    input  logic [11:0] ADC_i,
    input  logic [11:0] meanCurrent_i,
    input  logic [1:0]  mode_i,
    input  logic [1:0]  type_i,
    output logic        din_o,
    output logic        dataInReady_o,
    output logic [7:0]  dataIn_o,
    output logic [7:0]  sumChecker_o,
    output logic        checkSumBit_o
);

    localparam int              TW        = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0]   HALF_LAST = TW'(BIT_CYCLES / 2 - 1);
    localparam logic [TW-1:0]   BIT_LAST  = TW'(BIT_CYCLES - 1);
    localparam logic [4:0]      LAST_BIT  = 5'(FRAME_BITS - 1);

    logic                    en;
    rx_state_e               state_q;
    logic                    din_prev_q;
    logic [TW-1:0]           timer_q;
    logic [4:0]              cnt_q;
    logic [FRAME_BITS-2:0]   sr_q;
    logic [FRAME_BITS-1:0]   frame_d;
    logic                    sample;
    logic                    frame_ok;
    logic                    csb_d;
    logic                    ready_q;
    logic [7:0]              data_q;
    logic [7:0]              sum_q;
    logic                    csb_q;

    assign en = swiptAlive_i & (program_i == PROG_DATA) & readDataIn_i;

    read_data #(.HYST(HYST)) u_read_data (
        .clk    (clk),
        .nrst   (nrst),
        .en_i   (en),
        .adc_i  (ADC_i),
        .mean_i (meanCurrent_i),
        .din_o  (din_o)
    );

    // frame_d is the shift register as it will look once the current bit is taken.
    assign frame_d  = {sr_q, din_o};
    assign sample   = ((state_q == ALIGN) && (timer_q == HALF_LAST)) ||
                      ((state_q == SHIFT) && (timer_q == BIT_LAST));
    assign frame_ok = (frame_d[26:21] == PREAMBLE_RX) && (frame_d[3:0] == STOP_RX);
    assign csb_d    = (frame_d[12:5] == (frame_d[20:13] ^ {mode_i, type_i, mode_i, type_i})) &&
                      (frame_d[4] == ^frame_d[20:13]);

    always_ff @(posedge clk) begin
        if (sample) begin
            sr_q <= frame_d[FRAME_BITS-2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= HUNT;
            din_prev_q <= 1'b0;
            timer_q    <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            sum_q      <= '0;
            csb_q      <= 1'b0;
        end else if (!en) begin
            state_q    <= HUNT;
            din_prev_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            din_prev_q <= din_o;
            ready_q    <= 1'b0;
            unique case (state_q)
                HUNT: begin
                    if (din_o && !din_prev_q) begin
                        state_q <= ALIGN;
                        timer_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                ALIGN, SHIFT: begin
                    if (sample) begin
                        timer_q <= '0;
                        cnt_q   <= cnt_q + 5'd1;
                        state_q <= SHIFT;
                        if ((cnt_q == 5'd5) && (frame_d[5:0] != PREAMBLE_RX)) begin
                            state_q <= HUNT;
                        end else if (cnt_q == LAST_BIT) begin
                            // The ready cycle itself is the CHECK state.
                            if (frame_ok) begin
                                data_q  <= frame_d[20:13];
                                sum_q   <= frame_d[12:5];
                                csb_q   <= csb_d;
                                ready_q <= 1'b1;
                                state_q <= CHECK;
                            end else begin
                                state_q <= HUNT;
                            end
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                CHECK:   state_q <= HUNT;
                default: state_q <= HUNT;
            endcase
        end
    end

    assign dataInReady_o = ready_q;
    assign dataIn_o      = data_q;
    assign sumChecker_o  = sum_q;
    assign checkSumBit_o = csb_q;

endmodule

// File: tb/tb_analyse_data.sv
// Bench for analyse_data: drives ADC-level frames and scores reported frames
// against an expected-result queue.
module tb_analyse_data;

    localparam int BC = 16;

    logic        clk = 1'b0;
    logic        nrst;
    logic        swiptAlive;
    logic [1:0]  program_s;
    logic        readDataIn;
    logic [11:0] ADC;
    logic [11:0] meanCurrent;
    logic [1:0]  mode_s;
    logic [1:0]  type_s;
    logic        din;
    logic        dataInReady;
    logic [7:0]  dataIn;
    logic [7:0]  sumChecker;
    logic        checkSumBit;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] c;
        logic       csb;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   rpt_cnt = 0;
    bit   rdy_seen = 1'b0;

    analyse_data #(.BIT_CYCLES(BC), .HYST(12'd20)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .swiptAlive_i  (swiptAlive),
        .program_i     (program_s),
        .readDataIn_i  (readDataIn),
        .ADC_i         (ADC),
        .meanCurrent_i (meanCurrent),
        .mode_i        (mode_s),
        .type_i        (type_s),
        .din_o         (din),
        .dataInReady_o (dataInReady),
        .dataIn_o      (dataIn),
        .sumChecker_o  (sumChecker),
        .checkSumBit_o (checkSumBit)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [26:0] mk(input logic [5:0] pre, input logic [7:0] d,
                                       input logic [7:0] c, input logic p, input logic [3:0] stp);
        return {pre, d, c, p, stp};
    endfunction

    task automatic send_bits(input logic [26:0] f, input int nbits);
        for (int i = 26; i > 26 - nbits; i--) begin
            ADC = f[i] ? 12'd1100 : 12'd900;
            cyc(BC);
        end
        ADC = 12'd900;
    endtask

    // Monitor: every ready pulse is matched against the oldest expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (rdy_seen) begin
            check_eq("rdy_width", dataInReady, 0);
            rdy_seen = 1'b0;
        end else if (dataInReady) begin
            rdy_seen = 1'b1;
            rpt_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_rdy", dataInReady, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("dataIn", dataIn, e.d);
                check_eq("sumChecker", sumChecker, e.c);
                check_eq("checkSumBit", checkSumBit, e.csb);
            end
        end
    end

    initial begin
        nrst = 1'b0; swiptAlive = 1'b0; program_s = 2'b11; readDataIn = 1'b0;
        ADC = 12'd900; meanCurrent = 12'd1000; mode_s = 2'b01; type_s = 2'b10;
        cyc(3);
        check_eq("rst_din", din, 0);
        check_eq("rst_rdy", dataInReady, 0);
        check_eq("rst_dataIn", dataIn, 0);
        check_eq("rst_sum", sumChecker, 0);
        check_eq("rst_csb", checkSumBit, 0);

        nrst = 1'b1; swiptAlive = 1'b1; readDataIn = 1'b1;
        cyc(3);
        ADC = 12'd1015; cyc(1); check_eq("din_band_lo", din, 0);
        ADC = 12'd1030; cyc(1); check_eq("din_rise", din, 1);
        ADC = 12'd1015; cyc(1); check_eq("din_hold", din, 1);
        ADC = 12'd975;  cyc(1); check_eq("din_fall", din, 0);
        ADC = 12'd900;  readDataIn = 1'b0; cyc(2);
        readDataIn = 1'b1; cyc(4);

        // A5 ^ 66 = C3, parity of A5 is 0
        exp_q.push_back('{d: 8'hA5, c: 8'hC3, csb: 1'b1});
        send_bits(mk(6'b101010, 8'hA5, 8'hC3, 1'b0, 4'b0101), 27);
        cyc(500);
        check_eq("pending_1", exp_q.size(), 0);

        exp_q.push_back('{d: 8'hA5, c: 8'h3F, csb: 1'b0});
        send_bits(mk(6'b101010, 8'hA5, 8'h3F, 1'b0, 4'b0101), 27);
        cyc(500);
        check_eq("pending_2", exp_q.size(), 0);

        exp_q.push_back('{d: 8'hA5, c: 8'h00, csb: 1'b0});
        send_bits(mk(6'b101010, 8'hA5, 8'h00, 1'b0, 4'b0101), 27);
        cyc(500);
        check_eq("pending_3", exp_q.size(), 0);

        send_bits(mk(6'b101110, 8'h5A, 8'h00, 1'b0, 4'b0101), 27);
        cyc(500);
        check_eq("badpre_dataIn", dataIn, 8'hA5);
        check_eq("badpre_sum", sumChecker, 8'h00);
        check_eq("badpre_csb", checkSumBit, 0);

        send_bits(mk(6'b101010, 8'h5A, 8'h00, 1'b0, 4'b0111), 27);
        cyc(500);
        check_eq("badstop_dataIn", dataIn, 8'hA5);
        check_eq("badstop_sum", sumChecker, 8'h00);
        check_eq("badstop_csb", checkSumBit, 0);
        check_eq("reports_before_abort", rpt_cnt, 3);

        // 3C ^ 66 = 5A, parity of 3C is 0
        send_bits(mk(6'b101010, 8'h3C, 8'h5A, 1'b0, 4'b0101), 11);
        readDataIn = 1'b0; cyc(1);
        check_eq("abort_din", din, 0);
        cyc(3);
        readDataIn = 1'b1; cyc(4);
        check_eq("abort_dataIn_held", dataIn, 8'hA5);
        exp_q.push_back('{d: 8'h3C, c: 8'h5A, csb: 1'b1});
        send_bits(mk(6'b101010, 8'h3C, 8'h5A, 1'b0, 4'b0101), 27);
        cyc(500);
        check_eq("pending_4", exp_q.size(), 0);
        check_eq("reports_after_abort", rpt_cnt, 4);

        nrst = 1'b0; cyc(2);
        check_eq("rst2_dataIn", dataIn, 0);
        check_eq("rst2_sum", sumChecker, 0);
        check_eq("rst2_csb", checkSumBit, 0);
        check_eq("rst2_din", din, 0);
        nrst = 1'b1; program_s = 2'b10; cyc(4);
        send_bits(mk(6'b101010, 8'hA5, 8'hC3, 1'b0, 4'b0101), 27);
        cyc(500);
        check_eq("prog_reports", rpt_cnt, 4);
        check_eq("prog_dataIn", dataIn, 0);
        check_eq("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
